// File: rtl/ej32_pkg.sv
// ej32_pkg: opcode encoding, sequencer descriptor type and the opcode descriptor table
// shared by the eJ32 instruction sequencer and its ROM.
package ej32_pkg;

   localparam int LAST_W   = 3;
   localparam int SMASK_W  = 2;
   localparam int BSY_DIV  = 0;
   localparam int BSY_MEM  = 1;
   localparam int MAX_LAST = 5;

   localparam logic [SMASK_W-1:0] SM_NONE = '0;
   localparam logic [SMASK_W-1:0] SM_DIV  = SMASK_W'(1 << BSY_DIV);
   localparam logic [SMASK_W-1:0] SM_MEM  = SMASK_W'(1 << BSY_MEM);

   typedef enum logic [7:0] {
      nop         = 8'h00,
      aconst_null = 8'h01,
      iconst_m1   = 8'h02,
      iconst_0    = 8'h03,
      iconst_1    = 8'h04,
      iconst_2    = 8'h05,
      iconst_3    = 8'h06,
      iconst_4    = 8'h07,
      iconst_5    = 8'h08,
      bipush      = 8'h10,
      sipush      = 8'h11,
      ldi         = 8'h12,
      iaload      = 8'h2e,
      baload      = 8'h33,
      saload      = 8'h35,
      iastore     = 8'h4f,
      pop2        = 8'h58,
      dup_x1      = 8'h5a,
      dup2        = 8'h5c,
      iadd        = 8'h60,
      isub        = 8'h64,
      imul        = 8'h68,
      idiv        = 8'h6c,
      irem        = 8'h70,
      iand        = 8'h7e,
      ior         = 8'h80,
      ixor        = 8'h82,
      iinc        = 8'h84,
      ifeq        = 8'h99,
      ifne        = 8'h9a,
      goto        = 8'ha7,
      jsr         = 8'ha8,
      ret         = 8'ha9,
      jreturn     = 8'hac,
      get         = 8'hba,
      put         = 8'hbb,
      op_err      = 8'hff
   } opcode_t;

   typedef struct packed {
      logic                au;
      logic                br;
      logic                ls;
      logic [LAST_W-1:0]   last;
      logic                step;
      logic [SMASK_W-1:0]  smask;
   } seq_desc_t;

   function automatic seq_desc_t mk_desc(input logic au, input logic br, input logic ls,
                                         input logic [LAST_W-1:0] last, input logic step,
                                         input logic [SMASK_W-1:0] smask);
      mk_desc = '{au: au, br: br, ls: ls, last: last, step: step, smask: smask};
   endfunction

   // op_err is deliberately absent: it is only ever produced by a failed load.
   function automatic logic op_legal(input logic [7:0] b);
      case (b)
         nop, aconst_null, iconst_m1, iconst_0, iconst_1, iconst_2, iconst_3, iconst_4,
         iconst_5, bipush, sipush, ldi, iaload, baload, saload, iastore, pop2, dup_x1,
         dup2, iadd, isub, imul, idiv, irem, iand, ior, ixor, iinc, ifeq, ifne, goto,
         jsr, ret, jreturn, get, put:
            op_legal = 1'b1;
         default:
            op_legal = 1'b0;
      endcase
   endfunction

   function automatic seq_desc_t seq_lookup(input opcode_t code);
      case (code)
         aconst_null, iconst_m1, iconst_0, iconst_1, iconst_2, iconst_3, iconst_4,
         iconst_5, iadd, isub, imul, iand, ior, ixor:
                  seq_lookup = mk_desc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, SM_NONE);
         idiv, irem:
                  seq_lookup = mk_desc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, SM_DIV);
         bipush:  seq_lookup = mk_desc(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, SM_NONE);
         sipush:  seq_lookup = mk_desc(1'b1, 1'b0, 1'b0, 3'd2, 1'b1, SM_NONE);
         ldi:     seq_lookup = mk_desc(1'b1, 1'b0, 1'b0, 3'd4, 1'b1, SM_NONE);
         iinc:    seq_lookup = mk_desc(1'b1, 1'b0, 1'b0, 3'd2, 1'b1, SM_NONE);
         pop2:    seq_lookup = mk_desc(1'b1, 1'b0, 1'b0, 3'd1, 1'b0, SM_NONE);
         dup_x1:  seq_lookup = mk_desc(1'b1, 1'b0, 1'b0, 3'd2, 1'b0, SM_NONE);
         dup2:    seq_lookup = mk_desc(1'b1, 1'b0, 1'b0, 3'd3, 1'b0, SM_NONE);
         iaload:  seq_lookup = mk_desc(1'b0, 1'b0, 1'b1, 3'd5, 1'b0, SM_MEM);
         iastore: seq_lookup = mk_desc(1'b0, 1'b0, 1'b1, 3'd5, 1'b0, SM_MEM);
         baload:  seq_lookup = mk_desc(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, SM_MEM);
         saload:  seq_lookup = mk_desc(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, SM_MEM);
         get:     seq_lookup = mk_desc(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, SM_MEM);
         put:     seq_lookup = mk_desc(1'b0, 1'b0, 1'b1, 3'd1, 1'b0, SM_MEM);
         ifeq, ifne, goto, jsr:
                  seq_lookup = mk_desc(1'b0, 1'b1, 1'b0, 3'd2, 1'b1, SM_NONE);
         ret:     seq_lookup = mk_desc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, SM_NONE);
         jreturn: seq_lookup = mk_desc(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, SM_NONE);
         default: seq_lookup = mk_desc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, SM_NONE);
      endcase
   endfunction

endpackage

// File: rtl/ej32_seq_rom.sv
// ej32_seq_rom: combinational opcode to sequencer descriptor lookup.
module ej32_seq_rom
   import ej32_pkg::*;
(
   input  opcode_t   code,
   output seq_desc_t desc
);

   always_comb begin
      desc = seq_lookup(code);
   end

endmodule

// File: rtl/ej32_seq.sv
// ej32_seq: table-driven eJ32 instruction sequencer; latches opcodes, steps phases,
// drives AU/BR/LS enables and PC advance, with stall, flush, freeze and illegal-op report.
module ej32_seq
   import ej32_pkg::*;
#(
   parameter int PH_W  = 3,
   parameter int BSY_N = 2,
   parameter int OP_W  = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             dc_en,
   input  logic             flush,
   input  logic [OP_W-1:0]  data,
   input  logic [BSY_N-1:0] bsy,
   output opcode_t          code,
   output logic [PH_W-1:0]  phase,
   output logic             au_en,
   output logic             br_en,
   output logic             ls_en,
   output logic             p_inc,
   output logic             err
);

   if (MAX_LAST >= (1 << PH_W)) begin : g_ph_w_check
      $error("ej32_seq: PH_W too narrow for the longest descriptor");
   end
   if (OP_W != 8) begin : g_op_w_check
      $error("ej32_seq: opcode_t is a byte, OP_W must be 8");
   end

   opcode_t         code_q, code_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic            err_q, err_d;
   seq_desc_t       desc;
   logic [PH_W-1:0] last;
   logic            stall;
   logic            at_last;
   logic            run;

   ej32_seq_rom u_rom (
      .code (code_q),
      .desc (desc)
   );

   assign last    = PH_W'(desc.last);
   assign stall   = |(bsy & BSY_N'(desc.smask));
   assign at_last = (phase_q >= last);
   assign run     = !rst && !flush && dc_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         code_q  <= nop;
         phase_q <= '0;
         err_q   <= 1'b0;
      end else begin
         code_q  <= code_d;
         phase_q <= phase_d;
         err_q   <= err_d;
      end
   end

   // Flush overrides freeze and stall; only an unstalled, enabled last phase loads data.
   always_comb begin
      code_d  = code_q;
      phase_d = phase_q;
      err_d   = 1'b0;
      if (flush) begin
         code_d  = nop;
         phase_d = '0;
      end else if (dc_en && !stall) begin
         if (!at_last) begin
            phase_d = phase_q + PH_W'(1);
         end else begin
            phase_d = '0;
            if (op_legal(data)) begin
               code_d = opcode_t'(data);
            end else begin
               code_d = op_err;
               err_d  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      au_en = 1'b0;
      br_en = 1'b0;
      ls_en = 1'b0;
      p_inc = 1'b0;
      if (run) begin
         au_en = desc.au;
         br_en = desc.br;
         ls_en = desc.ls;
         if (!stall) begin
            p_inc = at_last ? 1'b1 : desc.step;
         end
      end
   end

   assign code  = code_q;
   assign phase = phase_q;
   assign err   = err_q;

endmodule

// File: tb/tb_ej32_seq.sv
// tb_ej32_seq: directed test-plan steps followed by randomized traffic, checked against a
// remaining-phase-count reference model driven by a byte-indexed opcode property table.
module tb_ej32_seq;
   import ej32_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       dc_en;
   logic       flush;
   logic [7:0] data;
   logic [1:0] bsy;
   opcode_t    code;
   logic [2:0] phase;
   logic       au_en;
   logic       br_en;
   logic       ls_en;
   logic       p_inc;
   logic       err;

   ej32_seq #(.PH_W(3), .BSY_N(2), .OP_W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .dc_en (dc_en),
      .flush (flush),
      .data  (data),
      .bsy   (bsy),
      .code  (code),
      .phase (phase),
      .au_en (au_en),
      .br_en (br_en),
      .ls_en (ls_en),
      .p_inc (p_inc),
      .err   (err)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Opcode properties: unit 0 none, 1 AU, 2 BR, 3 LS.
   bit       t_legal [256];
   int       t_last  [256];
   bit       t_step  [256];
   int       t_unit  [256];
   bit [1:0] t_smask [256];
   int       legal_q [$];

   // Model state: opcode held, phases still to run after this one, pending err pulse.
   int m_code;
   int m_rem;
   bit m_err;

   task automatic setOp(input int b, input int unit, input int last, input bit step,
                        input bit [1:0] sm);
      t_legal[b] = 1'b1;
      t_unit[b]  = unit;
      t_last[b]  = last;
      t_step[b]  = step;
      t_smask[b] = sm;
      legal_q.push_back(b);
   endtask

   task automatic expectEq(input string tag, input int got, input int want);
      assert (got === want)
         else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
         end
   endtask

   task automatic checkOutput(input string tag);
      bit go;
      bit stl;
      bit exp_pinc;
      int exp_phase;
      go        = !rst && !flush && dc_en;
      stl       = |(bsy & t_smask[m_code]);
      exp_pinc  = go && !stl && (m_rem == 0 || t_step[m_code]);
      exp_phase = t_last[m_code] - m_rem;
      expectEq({tag, "/code"},  int'(code),  m_code);
      expectEq({tag, "/phase"}, int'(phase), exp_phase);
      expectEq({tag, "/p_inc"}, int'(p_inc), int'(exp_pinc));
      expectEq({tag, "/au_en"}, int'(au_en), int'(go && t_unit[m_code] == 1));
      expectEq({tag, "/br_en"}, int'(br_en), int'(go && t_unit[m_code] == 2));
      expectEq({tag, "/ls_en"}, int'(ls_en), int'(go && t_unit[m_code] == 3));
      expectEq({tag, "/err"},   int'(err),   int'(m_err));
   endtask

   task automatic modelStep();
      bit stl;
      stl   = |(bsy & t_smask[m_code]);
      m_err = 1'b0;
      if (rst || flush) begin
         m_code = 0;
         m_rem  = 0;
      end else if (!dc_en || stl) begin
      end else if (m_rem > 0) begin
         m_rem--;
      end else if (t_legal[data]) begin
         m_code = int'(data);
         m_rem  = t_last[data];
      end else begin
         m_code = 8'hff;
         m_rem  = 0;
         m_err  = 1'b1;
      end
   endtask

   task automatic applyStimulus(input bit r, input bit en, input bit fl, input logic [7:0] d,
                                input logic [1:0] b, input string tag);
      @(negedge clk);
      rst   = r;
      dc_en = en;
      flush = fl;
      data  = d;
      bsy   = b;
      #1;
      n_vec++;
      checkOutput(tag);
      modelStep();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         t_legal[i] = 1'b0;
         t_unit[i]  = 0;
         t_last[i]  = 0;
         t_step[i]  = 1'b0;
         t_smask[i] = 2'b00;
      end
      setOp(8'h00, 0, 0, 0, 2'b00);
      for (int b = 8'h01; b <= 8'h08; b++) setOp(b, 1, 0, 0, 2'b00);
      setOp(8'h10, 1, 1, 1, 2'b00);
      setOp(8'h11, 1, 2, 1, 2'b00);
      setOp(8'h12, 1, 4, 1, 2'b00);
      setOp(8'h2e, 3, 5, 0, 2'b10);
      setOp(8'h33, 3, 2, 0, 2'b10);
      setOp(8'h35, 3, 3, 0, 2'b10);
      setOp(8'h4f, 3, 5, 0, 2'b10);
      setOp(8'h58, 1, 1, 0, 2'b00);
      setOp(8'h5a, 1, 2, 0, 2'b00);
      setOp(8'h5c, 1, 3, 0, 2'b00);
      setOp(8'h60, 1, 0, 0, 2'b00);
      setOp(8'h64, 1, 0, 0, 2'b00);
      setOp(8'h68, 1, 0, 0, 2'b00);
      setOp(8'h7e, 1, 0, 0, 2'b00);
      setOp(8'h80, 1, 0, 0, 2'b00);
      setOp(8'h82, 1, 0, 0, 2'b00);
      setOp(8'h6c, 1, 0, 0, 2'b01);
      setOp(8'h70, 1, 0, 0, 2'b01);
      setOp(8'h84, 1, 2, 1, 2'b00);
      setOp(8'h99, 2, 2, 1, 2'b00);
      setOp(8'h9a, 2, 2, 1, 2'b00);
      setOp(8'ha7, 2, 2, 1, 2'b00);
      setOp(8'ha8, 2, 2, 1, 2'b00);
      setOp(8'ha9, 2, 0, 0, 2'b00);
      setOp(8'hac, 2, 1, 0, 2'b00);
      setOp(8'hba, 3, 2, 0, 2'b10);
      setOp(8'hbb, 3, 1, 0, 2'b10);

      rst   = 1'b1;
      dc_en = 1'b1;
      flush = 1'b0;
      data  = 8'h00;
      bsy   = 2'b00;
      repeat (2) @(posedge clk);
      m_code = 0;
      m_rem  = 0;
      m_err  = 1'b0;

      applyStimulus(1, 1, 0, 8'h60, 2'b00, "reset");
      expectEq("reset_pinc", int'(p_inc), 0);

      // iadd stream: first cycle after reset runs nop, then one iadd per cycle.
      applyStimulus(0, 1, 0, 8'h60, 2'b00, "nop_first");
      applyStimulus(0, 1, 0, 8'h60, 2'b00, "iadd0");
      applyStimulus(0, 1, 0, 8'h60, 2'b00, "iadd1");
      expectEq("iadd_au", int'(au_en), 1);
      expectEq("iadd_pinc", int'(p_inc), 1);
      applyStimulus(0, 1, 0, 8'h11, 2'b00, "iadd2");

      applyStimulus(0, 1, 0, 8'haa, 2'b00, "sipush0");
      applyStimulus(0, 1, 0, 8'hbb, 2'b00, "sipush1");
      applyStimulus(0, 1, 0, 8'h2e, 2'b00, "sipush2");
      expectEq("sipush_ph2", int'(phase), 2);

      for (int p = 0; p < 6; p++) begin
         applyStimulus(0, 1, 0, (p == 5) ? 8'h6c : 8'h60, 2'b00, "iaload");
         expectEq("iaload_pinc", int'(p_inc), (p == 5) ? 1 : 0);
      end

      for (int s = 0; s < 4; s++) applyStimulus(0, 1, 0, 8'h4f, 2'b01, "idiv_stall");
      applyStimulus(0, 1, 0, 8'h4f, 2'b00, "idiv_rel");
      expectEq("idiv_rel_pinc", int'(p_inc), 1);

      applyStimulus(0, 1, 0, 8'h60, 2'b00, "iastore0");
      applyStimulus(0, 0, 0, 8'h60, 2'b00, "freeze");
      expectEq("freeze_ls", int'(ls_en), 0);
      applyStimulus(0, 1, 0, 8'h60, 2'b00, "iastore1");
      applyStimulus(0, 1, 0, 8'h60, 2'b00, "iastore2");
      applyStimulus(0, 1, 1, 8'h60, 2'b00, "flush_ph3");
      expectEq("flush_phase", int'(phase), 3);
      applyStimulus(0, 1, 0, 8'h11, 2'b00, "post_flush");
      expectEq("post_flush_code", int'(code), 8'h00);

      applyStimulus(0, 1, 0, 8'h60, 2'b00, "sipush_a");
      applyStimulus(0, 1, 0, 8'h60, 2'b00, "sipush_b");
      applyStimulus(1, 1, 0, 8'h60, 2'b00, "rst_ph2");
      applyStimulus(0, 1, 0, 8'hff, 2'b00, "post_rst");
      expectEq("post_rst_phase", int'(phase), 0);

      applyStimulus(0, 1, 0, 8'h60, 2'b00, "op_err");
      expectEq("op_err_err", int'(err), 1);
      expectEq("op_err_code", int'(code), 8'hff);
      applyStimulus(0, 1, 0, 8'h60, 2'b00, "after_err");
      expectEq("after_err_err", int'(err), 0);

      for (int n = 0; n < 800; n++) begin
         logic [7:0] d;
         if ($urandom_range(0, 99) < 80) d = 8'(legal_q[$urandom_range(0, legal_q.size() - 1)]);
         else d = 8'($urandom_range(0, 255));
         applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) >= 10,
                       $urandom_range(0, 99) < 4, d,
                       ($urandom_range(0, 99) < 35) ? 2'($urandom_range(1, 3)) : 2'b00,
                       "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ej32_seq.md
# ej32_seq

Parametrised, table-driven instruction sequencer for the eJ32 core; successor to the decoder unit. It latches each opcode byte from the memory bus and steps a phase counter through a per-opcode descriptor. It drives the unit enables (AU/BR/LS) and program-counter advance, and stalls on a generic vector of unit-busy lines rather than a single divider flag. Adds flush, illegal-opcode reporting and an enable freeze; sits between the memory bus and the AU/BR/LS units.

## Interface
- `PH_W`, 3: phase counter width; max last-phase index 2^PH_W−1.
- `BSY_N`, 2: number of busy/stall sources; bit 0 = divider, bit 1 = memory.
- `OP_W`, 8: opcode byte width.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `dc_en`  in  1: sequencer enable; low freezes state.
- `flush`  in  1: abort current opcode (branch redirect).
- `data`  in  OP_W: opcode byte from memory bus, sampled at opcode load.
- `bsy`  in  BSY_N: unit busy lines.
- `code`  out  opcode_t: current opcode, to control bus.
- `phase`  out  PH_W: current phase, to control bus.
- `au_en`, `br_en`, `ls_en`  out  1 each: unit enables.
- `p_inc`  out  1: advance program counter this cycle.
- `err`  out  1: one-cycle pulse when an illegal byte is loaded.

## Operation
- Descriptor lookup `seq_lookup(code)` returns `{au, br, ls, last[PH_W], step, smask[BSY_N]}`.
- `step`=1 (STEP type) fetches operand bytes per phase; `step`=0 (WAIT type) holds the PC.
- `stall = |(bsy & smask)`.
- Priority per cycle: `rst` > `flush` > `!dc_en` > `stall` > normal.
- Normal, `phase < last`:
  - `phase <= phase+1`; `code` held.
  - `p_inc = step`.
- Normal, `phase == last`:
  - `phase <= 0`; `code <= cast(data)`.
  - `p_inc = 1`.
  - A single-cycle opcode has `last = 0`.
- Stall: `phase` and `code` held, `p_inc = 0`, unit enables stay at descriptor values.
  - Stall and release are symmetric at every phase. No special-case patch path.
- `!dc_en`: state held; `p_inc`, `au_en`, `br_en`, `ls_en` all 0.
- `flush`:
  - `code <= nop`, `phase <= 0`; `p_inc = 0` that cycle.
  - Takes effect regardless of `stall` or `dc_en`.
- Illegal byte (cast fails) at load:
  - `code <= op_err`, and `err` pulses 1 in the following cycle.
  - `op_err` descriptor: all enables 0, `last = 0`.
- Descriptor `last` values:
  - 0 for constants, ALU ops, `ret`.
  - 1 for `bipush`, `pop2`, `put`, `jreturn`.
  - 2 for `sipush`, branches, `baload`, `dup_x1`, `iinc`, `jsr`, `get`.
  - 3 for `saload`, `dup2`.
  - 4 for `ldi`.
  - 5 for `iaload`, `iastore`.
- `idiv`/`irem`: `last = 0`, `smask` bit 0 set. The divider asserts `bsy[0]` combinationally in the first cycle `code` is `idiv`/`irem`.

## Timing
- Reset values:
  - `code = nop`, `phase = 0`, `err = 0`.
  - While `rst` is high: `p_inc = 0` and all enables 0.
- `p_inc` and the enables are combinational from `code`, `phase`, `bsy`, `dc_en`, `flush`, `rst`. They are valid in the same cycle.
- Opcode load latency: byte on `data` in the final-phase cycle appears on `code` after 1 edge.
- An opcode with last phase L and no stall occupies L+1 cycles.
  - STEP type asserts `p_inc` in all L+1 cycles.
  - WAIT type asserts `p_inc` only in the last.
- Stall cycles add 1:1 to occupancy.
- Reset mid-sequence discards the opcode. The first cycle after reset executes `nop`, then loads from `data`.
- `flush` together with `phase == last`: flush wins; `data` is not loaded.
- Phase never exceeds `last`; no wrap beyond 2^PH_W−1. Assert `last < 2^PH_W` at elaboration.

## Structure
- `ej32_pkg` holds:
  - the `seq_desc_t` struct;
  - the `seq_lookup()` function;
  - `BSY_DIV`, `BSY_MEM` bit indices;
  - the `nop`/`op_err` opcodes.
- One sub-module: `ej32_seq_rom`, a combinational opcode→descriptor lookup. The sequencer core holds the phase/code registers and priority logic.

## Test plan
- `iadd` (0x60) stream after reset, `dc_en`=1: `au_en`=1 and `p_inc`=1 every cycle; `code` reloads each cycle.
- `sipush` (0x11): phases 0,1,2 with `p_inc`=1 in all three; `code` held for 2 cycles, next opcode loaded on the 3rd edge.
- `iaload` (0x2e): `ls_en`=1; `p_inc`=0 for 5 cycles (phases 0–4), 1 at phase 5, then next load.
- `idiv` (0x6c) with `bsy[0]` high 4 cycles:
  - `phase` stays 0 and `p_inc`=0 for those 4 cycles;
  - on the release cycle `p_inc`=1 and the next byte loads. No extra cycle.
- `flush` at phase 3 of `iastore`: next cycle `code`=nop, `phase`=0, `p_inc`=0 during the flush cycle. Then `rst` asserted at phase 2 of `sipush`: `code`=nop, `phase`=0.
- Byte 0xff loaded: `code`=`op_err`, `err`=1 for exactly one cycle, enables 0, following byte loads next cycle.
